serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, sampled only on start acceptance.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, sampled only on start acceptance.
REQ-007 The block SHALL have port bin, input, 1 bit: borrow-in, sampled only on start acceptance.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the block is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle result-valid pulse.
REQ-010 The block SHALL have port diff, output, WIDTH bits: a - b - bin, modulo 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1 bit: final borrow-out, set when a < b + bin (unsigned).

Function
REQ-012 The block SHALL compute the result bit-serially, LSB first, one bit per SHIFT cycle, with a 1-bit borrow register.
- Per-bit equations: d = x ^ y ^ br; br_next = (~x & (x^y... see REQ-013.
REQ-013 Each bit step SHALL use the full-subtractor equations:
- d = x ^ y ^ br
- br_next = (~x & (y ^ br)) | (y & br)
- x, y are the current LSBs of the operand shift registers.
REQ-014 The state machine SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE with start=1, the next edge SHALL load a and b into shift registers, load bin into the borrow register, clear the bit counter and enter SHIFT.
REQ-016 In SHIFT, each edge SHALL:
- shift both operand registers right by one;
- shift d into the MSB of the result register;
- update the borrow register;
- increment the counter.
REQ-017 After exactly WIDTH SHIFT edges, the block SHALL enter DONE.
REQ-018 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-019 done SHALL first be high in the cycle following the WIDTH-th edge after the accepting edge.
REQ-020 busy SHALL be high in all SHIFT and DONE cycles and low in IDLE.
REQ-021 diff and bout SHALL be valid while done=1 and SHALL hold that value until the next accepted start or reset.
REQ-022 start SHALL be ignored while busy=1; a start held high in DONE SHALL be accepted on the first IDLE edge.
REQ-023 Changes on a, b and bin after acceptance SHALL NOT affect the operation in progress.
REQ-024 Back-to-back operation SHALL sustain one result per WIDTH+2 cycles.

Reset
REQ-025 When rst=1 at a rising edge, the block SHALL enter IDLE and clear busy, done, diff, bout, the counter, the borrow register and the operand registers to 0.
REQ-026 rst SHALL take priority over start and over any in-progress operation.
- Reset mid-SHIFT aborts the operation; no done pulse follows.
REQ-027 The first start after rst deasserts SHALL be accepted on the first edge with rst=0.

Verification
REQ-028 WIDTH=8: a=0x5A, b=0x3C, bin=0, start pulse -> exactly 8 edges later done=1, diff=0x1E, bout=0.
REQ-029 WIDTH=8: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
REQ-030 WIDTH=8: a=0x80, b=0x80, bin=1 -> diff=0xFF, bout=1; a=0xFF, b=0x00, bin=1 -> diff=0xFE, bout=0.
REQ-031 Start a=0x12, b=0x34; pulse start again with a=0x77 at SHIFT cycle 3 -> second start ignored; result diff=0xDE, bout=1; done pulses once.
REQ-032 Assert rst at SHIFT cycle 4 -> next cycle busy=0, diff=0x00, bout=0; no done pulse; a new start then yields a correct result.
REQ-033 Random regression, 1000 operations, held start, WIDTH in {2, 8, 32}:
- diff/bout match the reference model {bout,diff} = a - b - bin;
- done spacing is exactly WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes {bout, diff} = a - b - bin, LSB first, one bit per cycle.
// One result every WIDTH+2 cycles: load edge, WIDTH shift edges, one DONE cycle.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("serial_subtractor: WIDTH must be in 2..32");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_res;
   logic [WIDTH-1:0]   r_diff;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_br;
   logic               r_bout;
   logic               r_busy;
   logic               r_done;
   logic               w_load;
   logic               w_shift;
   logic               w_cnt_last;
   logic               w_x;
   logic               w_y;
   logic               w_d;
   logic               w_br_next;

   // Full-subtractor slice on the current operand LSBs
   assign w_x        = r_a[0];
   assign w_y        = r_b[0];
   assign w_d        = w_x ^ w_y ^ r_br;
   assign w_br_next  = (~w_x & (w_y ^ r_br)) | (w_y & r_br);
   assign w_cnt_last = (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_SHIFT;
         S_SHIFT: if (w_cnt_last) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_load  = 1'b0;
      w_shift = 1'b0;
      case (r_state)
         S_IDLE:  w_load  = start;
         S_SHIFT: w_shift = 1'b1;
         default: ;
      endcase
   end

   // Datapath; the published result only changes on the last shift edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_res  <= '0;
         r_br   <= 1'b0;
         r_cnt  <= '0;
         r_diff <= '0;
         r_bout <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_state_next != S_IDLE);
         r_done <= (w_state_next == S_DONE);
         if (w_load) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
         end else if (w_shift) begin
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_br  <= w_br_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_cnt_last) begin
               r_diff <= {w_d, r_res[WIDTH-1:1]};
               r_bout <= w_br_next;
            end
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign diff = r_diff;
   assign bout = r_bout;

endmodule
